// File: rtl/l2_cache_nway_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : l2_cache_nway_if
// Desc   : Upstream line bus, physical-memory bus and perf counters of the L2.
// Rev    : 1.0 - initial release
// ============================================================================
interface l2_cache_nway_if #(
    parameter int CNT_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [15:0]       mem_address;
    logic [127:0]      mem_wdata;
    logic              mem_resp;
    logic [127:0]      mem_rdata;
    logic              pmem_resp;
    logic [127:0]      pmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [15:0]       pmem_address;
    logic [127:0]      pmem_wdata;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    // Cache side
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
        output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
        output hit_count, miss_count
    );

    // Upstream requester plus physical-memory model
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
        input  mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  hit_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/l2_cache_nway.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : l2_cache_nway
// Desc   : N-way set-associative write-back/write-allocate L2 with true LRU.
// Rev    : 1.0 - initial release
// ============================================================================
module l2_cache_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int CNT_W = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    l2_cache_nway_if.slave   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 12 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam logic [WAY_W-1:0] c_oldest = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_valid [WAYS][SETS];
    logic               r_dirty [WAYS][SETS];
    logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
    logic [127:0]       r_data  [WAYS][SETS];
    logic [WAY_W-1:0]   r_age   [WAYS][SETS];

    logic [WAY_W-1:0]   r_victim;
    logic [11:0]        r_miss_line;
    logic               r_missed;
    logic               r_pmem_read;
    logic               r_pmem_write;
    logic [CNT_W-1:0]   r_hit_count;
    logic [CNT_W-1:0]   r_miss_count;

    logic [IDX_W-1:0]   w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_req;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic [WAY_W-1:0]   w_victim;
    logic               w_found_invalid;
    logic [IDX_W-1:0]   w_miss_idx;
    logic               w_unused_offset;

    assign w_index         = bus.mem_address[4 +: IDX_W];
    assign w_tag           = bus.mem_address[15 -: TAG_W];
    assign w_req           = bus.mem_read | bus.mem_write;
    assign w_miss_idx      = r_miss_line[IDX_W-1:0];
    assign w_unused_offset = ^bus.mem_address[3:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_index] && (r_tag[w][w_index] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the oldest (age WAYS-1).
    always_comb begin
        w_victim        = '0;
        w_found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found_invalid && !r_valid[w][w_index]) begin
                w_victim        = WAY_W'(w);
                w_found_invalid = 1'b1;
            end
        end
        if (!w_found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w][w_index] == c_oldest) begin
                    w_victim = WAY_W'(w);
                end
            end
        end
    end

    assign bus.mem_resp     = (r_state == IDLE) && w_req && w_hit;
    assign bus.mem_rdata    = r_data[w_hit_way][w_index];
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = (r_state == WRITEBACK)
                            ? {r_tag[r_victim][w_miss_idx], w_miss_idx, 4'b0000}
                            : {r_miss_line, 4'b0000};
    assign bus.pmem_wdata   = r_data[r_victim][w_miss_idx];
    assign bus.hit_count    = r_hit_count;
    assign bus.miss_count   = r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_victim     <= '0;
            r_miss_line  <= '0;
            r_missed     <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_age[w][s]   <= WAY_W'(w);
                end
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        if (bus.mem_write) begin
                            r_data[w_hit_way][w_index]  <= bus.mem_wdata;
                            r_dirty[w_hit_way][w_index] <= 1'b1;
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == w_hit_way) begin
                                r_age[w][w_index] <= '0;
                            end else if (r_age[w][w_index] < r_age[w_hit_way][w_index]) begin
                                r_age[w][w_index] <= r_age[w][w_index] + 1'b1;
                            end
                        end
                        // The hit that closes out a miss is not a real hit.
                        if (r_missed) begin
                            r_missed <= 1'b0;
                        end else begin
                            r_hit_count <= r_hit_count + 1'b1;
                        end
                    end else if (w_req) begin
                        r_victim     <= w_victim;
                        r_miss_line  <= bus.mem_address[15:4];
                        r_miss_count <= r_miss_count + 1'b1;
                        r_missed     <= 1'b1;
                        if (r_valid[w_victim][w_index] && r_dirty[w_victim][w_index]) begin
                            r_pmem_write <= 1'b1;
                            r_state      <= WRITEBACK;
                        end else begin
                            r_pmem_read  <= 1'b1;
                            r_state      <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        r_pmem_write <= 1'b0;
                        r_pmem_read  <= 1'b1;
                        r_state      <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        r_data[r_victim][w_miss_idx]  <= bus.pmem_rdata;
                        r_tag[r_victim][w_miss_idx]   <= r_miss_line[11 -: TAG_W];
                        r_valid[r_victim][w_miss_idx] <= 1'b1;
                        r_dirty[r_victim][w_miss_idx] <= 1'b0;
                        r_pmem_read                   <= 1'b0;
                        r_state                       <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_cache_nway.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_l2_cache_nway
// Desc   : Directed scoreboard bench for l2_cache_nway with a 3-cycle memory.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_l2_cache_nway;
    localparam int FILL_LAT = 3;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } pmem_ev_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   overlap;
    int   wait_cnt;

    logic [15:0]  exp_hits;
    logic [15:0]  exp_misses;
    logic [127:0] exp_q[$];
    pmem_ev_t     log_q[$];
    logic [127:0] pmem_model[logic [11:0]];
    logic [127:0] ref_mem[logic [11:0]];

    l2_cache_nway_if #(.CNT_W(16)) bus ();

    l2_cache_nway #(.WAYS(4), .SETS(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] init_line(input logic [11:0] l);
        return {8{l, 4'h5}};
    endfunction

    function automatic logic [127:0] ref_line(input logic [11:0] l);
        return ref_mem.exists(l) ? ref_mem[l] : init_line(l);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Physical memory: answers each strobe FILL_LAT cycles after it is seen.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        wait_cnt       = 0;
        forever begin
            @(negedge clk);
            if (bus.pmem_read && bus.pmem_write) overlap++;
            if (reset) begin
                bus.pmem_resp = 1'b0;
                wait_cnt      = 0;
            end else if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                wait_cnt      = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                wait_cnt++;
                if (wait_cnt == FILL_LAT) begin
                    if (bus.pmem_write) begin
                        pmem_model[bus.pmem_address[15:4]] = bus.pmem_wdata;
                        log_q.push_back('{1'b1, bus.pmem_address, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = pmem_model.exists(bus.pmem_address[15:4])
                                       ? pmem_model[bus.pmem_address[15:4]]
                                       : init_line(bus.pmem_address[15:4]);
                        log_q.push_back('{1'b0, bus.pmem_address, bus.pmem_rdata});
                    end
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, output int lat, output logic [127:0] rdata);
        @(negedge clk);
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.mem_address = addr;
        bus.mem_wdata   = wd;
        lat = 0;
        #1;
        while (!bus.mem_resp && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("resp_timeout", {127'b0, bus.mem_resp}, 128'd1);
        rdata = bus.mem_rdata;
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [127:0] wd, input logic exp_hit);
        int lat;
        logic [127:0] rdata;
        logic [127:0] e;
        if (rd && !wr) exp_q.push_back(ref_line(addr[15:4]));
        do_req(rd, wr, addr, wd, lat, rdata);
        check($sformatf("hit_%h", addr), (lat == 0) ? 128'd1 : 128'd0, {127'b0, exp_hit});
        if (exp_hit) exp_hits++;
        else         exp_misses++;
        if (wr) ref_mem[addr[15:4]] = wd;
        if (rd && !wr) begin
            e = exp_q.pop_front();
            check($sformatf("rdata_%h", addr), rdata, e);
        end
        check("hit_count", bus.hit_count, exp_hits);
        check("miss_count", bus.miss_count, exp_misses);
    endtask

    task automatic check_log(input logic wr, input logic [15:0] addr, input logic [127:0] data);
        pmem_ev_t ev;
        checks++;
        assert (log_q.size() != 0) else begin
            errors++;
            $error("FAIL pmem_log_empty observed=0 expected=%0d", 1);
        end
        if (log_q.size() != 0) begin
            ev = log_q.pop_front();
            check("pmem_kind", {127'b0, ev.wr}, {127'b0, wr});
            check("pmem_address", {112'b0, ev.addr}, {112'b0, addr});
            check("pmem_data", ev.data, data);
        end
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; overlap = 0;
        exp_hits = '0; exp_misses = '0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_address = '0; bus.mem_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_resp", {127'b0, bus.mem_resp}, 128'd0);
        check("rst_pmem_read", {127'b0, bus.pmem_read}, 128'd0);
        check("rst_pmem_write", {127'b0, bus.pmem_write}, 128'd0);
        check("rst_hit_count", {112'b0, bus.hit_count}, 128'd0);
        check("rst_miss_count", {112'b0, bus.miss_count}, 128'd0);
        reset = 1'b0;

        // Cold read: a single fill, then the same line hits.
        log_q.delete();
        access(1'b1, 1'b0, 16'h1230, '0, 1'b0);
        check_log(1'b0, 16'h1230, init_line(12'h123));
        access(1'b1, 1'b0, 16'h1230, '0, 1'b1);

        // LRU on index 3: 0x0130 becomes the oldest once 0x0030 is touched.
        access(1'b1, 1'b0, 16'h0030, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0130, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0230, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0330, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0030, '0, 1'b1);
        log_q.delete();
        access(1'b1, 1'b0, 16'h0430, '0, 1'b0);
        check_log(1'b0, 16'h0430, init_line(12'h043));
        check("clean_evict_no_wb", log_q.size(), 128'd0);
        access(1'b1, 1'b0, 16'h0030, '0, 1'b1);
        access(1'b1, 1'b0, 16'h0230, '0, 1'b1);
        access(1'b1, 1'b0, 16'h0330, '0, 1'b1);
        access(1'b1, 1'b0, 16'h0430, '0, 1'b1);
        access(1'b1, 1'b0, 16'h0130, '0, 1'b0);

        // Dirty eviction: writeback of B precedes the fill.
        access(1'b0, 1'b1, 16'h0050, {4{32'hB0B0_0001}}, 1'b0);
        access(1'b1, 1'b0, 16'h0150, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0250, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0350, '0, 1'b0);
        log_q.delete();
        access(1'b1, 1'b0, 16'h0450, '0, 1'b0);
        check_log(1'b1, 16'h0050, {4{32'hB0B0_0001}});
        check_log(1'b0, 16'h0450, init_line(12'h045));
        access(1'b1, 1'b0, 16'h0050, '0, 1'b0);

        // Simultaneous read+write hit, then evict to see the dirty line C.
        access(1'b1, 1'b0, 16'h0070, '0, 1'b0);
        access(1'b1, 1'b1, 16'h0070, {4{32'hC0C0_0002}}, 1'b1);
        access(1'b1, 1'b0, 16'h0070, '0, 1'b1);
        access(1'b1, 1'b0, 16'h0170, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0270, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0370, '0, 1'b0);
        log_q.delete();
        access(1'b1, 1'b0, 16'h0470, '0, 1'b0);
        check_log(1'b1, 16'h0070, {4{32'hC0C0_0002}});
        check_log(1'b0, 16'h0470, init_line(12'h047));

        // Reset in the middle of a fill.
        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_address = 16'h0090;
        n = 0;
        while (!bus.pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midfill_pmem_read", {127'b0, bus.pmem_read}, 128'd1);
        @(negedge clk);
        reset        = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        #1;
        check("midfill_rst_pmem_read", {127'b0, bus.pmem_read}, 128'd0);
        check("midfill_rst_pmem_write", {127'b0, bus.pmem_write}, 128'd0);
        check("midfill_rst_hits", {112'b0, bus.hit_count}, 128'd0);
        check("midfill_rst_misses", {112'b0, bus.miss_count}, 128'd0);
        @(negedge clk);
        reset      = 1'b0;
        exp_hits   = '0;
        exp_misses = '0;
        access(1'b1, 1'b0, 16'h0090, '0, 1'b0);
        access(1'b1, 1'b0, 16'h0090, '0, 1'b1);

        check("pmem_strobe_overlap", overlap, 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/l2_cache_nway.md
Name: l2_cache_nway

Overview:
- Parametrised successor to the two-way L2: an N-way set-associative, write-back, write-allocate cache between the L1 caches/arbiter (128-bit line interface) and physical memory.
- Way count and set count are generalised.
- Adds true-LRU replacement via per-line age counters, a first-invalid-way fill policy, and hit/miss performance counters.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 8, sets per way; power of two, 2..64.
- CNT_W, 16, width of hit/miss counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  read request from upstream; held until mem_resp
- mem_write  in  1  write request from upstream; held until mem_resp
- mem_address  in  16  byte address; [3:0] offset ignored
- mem_wdata  in  128  full-line write data
- mem_resp  out  1  request complete
- mem_rdata  out  128  line data; valid while mem_resp=1
- pmem_resp  in  1  physical memory done
- pmem_rdata  in  128  fill data
- pmem_read  out  1  line fill request
- pmem_write  out  1  line write-back request
- pmem_address  out  16  line address, [3:0]=0
- pmem_wdata  out  128  victim line data
- hit_count  out  CNT_W  requests satisfied without a miss
- miss_count  out  CNT_W  requests that missed

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Address split:
  - IDX_W = log2(SETS); index = mem_address[4+IDX_W-1:4].
  - tag = mem_address[15:4+IDX_W].
- Storage per way/set: valid, dirty, tag, 128-bit data, age of log2(WAYS) bits. Arrays are read asynchronously and written on the clk edge.
- Reset:
  - All valid and dirty bits clear; ages[w] = w.
  - Counters 0; state IDLE.
  - mem_resp, pmem_read, pmem_write = 0. pmem_address and pmem_wdata are don't-care while their strobes are 0.
  - A reset asserted mid-miss abandons the transaction: strobes drop the following cycle and no array is updated.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, no request: all outputs deasserted.
- IDLE, request (mem_read|mem_write) with hit (valid && tag match in some way w):
  - mem_resp=1 combinationally in the same cycle (1-cycle hit); mem_rdata = data[w].
  - If mem_write: data[w] <= mem_wdata, dirty[w] <= 1. If both mem_read and mem_write are high, the write is performed.
  - LRU update at the edge: age[w] <= 0; every way with age < old age[w] increments; the others hold.
  - hit_count increments, unless this hit completes a request that already missed.
- IDLE, request with miss:
  - Victim = lowest-numbered invalid way; if all ways are valid, the way with age == WAYS-1.
  - Victim is latched; miss_count increments; a missed flag is set.
  - Next state: WRITEBACK if the victim is valid and dirty, otherwise FILL.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim_tag, index, 4'b0}; pmem_wdata = victim data.
  - Holds until pmem_resp, then goes to FILL with pmem_write deasserted.
- FILL:
  - pmem_read=1; pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: victim data <= pmem_rdata, tag updated, valid=1, dirty=0; return to IDLE.
  - The request then hits in IDLE, giving minimum miss latency = fill latency + 1 cycle. That hit applies any write, the LRU update, and clears the missed flag; it is not counted in hit_count.
- mem_resp is never asserted outside IDLE.
- pmem_read and pmem_write are never asserted together.
- Counters wrap modulo 2^CNT_W.
- Upstream must hold address and data stable until mem_resp. A request dropped mid-miss still completes its fill.

Test Plan:
- Cold read 0x1230 (WAYS=4, SETS=8): one FILL to pmem_address 0x1230; pmem_rdata=A returned after 3 cycles -> mem_resp with mem_rdata=A; miss_count=1, hit_count=0. Re-read -> mem_resp same cycle, hit_count=1.
- Fill five tags mapping to index 3 (0x0030, 0x0130, 0x0230, 0x0330, then 0x0430) after touching 0x0030 last -> victim is 0x0130's way; 0x0030 still hits.
- Write 0x0050 data B (miss, then write), then force its eviction -> WRITEBACK with pmem_address 0x0050 and pmem_wdata=B precedes FILL; no pmem_read overlap.
- Clean-victim eviction -> no pmem_write; FILL only.
- Assert reset during FILL while pmem_read=1 -> pmem_read=0 next cycle, counters 0; a subsequent read of the same address misses.
- Simultaneous mem_read and mem_write hit on 0x0070 with C -> line becomes C, dirty set, mem_resp in 1 cycle.
